// File: rtl/sm2_pkg.sv
// rtl/sm2_pkg.sv - shared SM2 datapath constants and multiplier FSM state type
//
// Purpose : Default operand/digit widths for the SM2 field datapath and the
//           state encoding used by the digit-serial multiplier.
// Ports   : none (package).

package sm2_pkg;

  localparam int SM2_WIDTH = 256;
  localparam int SM2_DIGIT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_serial_if.sv
// rtl/mul_serial_if.sv - operand/product handshake bundle for mul_serial
//
// Purpose : Groups the operand (in_*) and product (out_*) valid/ready
//           handshakes of the serial multiplier.
// Ports   : in_valid/in_ready/a/b  operand handshake (producer -> multiplier)
//           out_valid/out_ready/c  product handshake (multiplier -> consumer)
// Modports: master - the side that supplies operands and consumes c
//           slave  - the multiplier itself

interface mul_serial_if
  import sm2_pkg::*;
#(
  parameter int WIDTH = SM2_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   c;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c
  );

endinterface

// File: rtl/mul_digit.sv
// rtl/mul_digit.sv - combinational DIGIT x DIGIT unsigned multiplier
//
// Purpose : The single multiplier used by mul_serial; swap this body for a
//           vendor multiplier/DSP macro when targeting a specific device.
// Ports   : x, y  DIGIT-bit unsigned operands
//           p     2*DIGIT-bit unsigned product

module mul_digit #(
  parameter int DIGIT = 64
) (
  input  logic [DIGIT-1:0]   x,
  input  logic [DIGIT-1:0]   y,
  output logic [2*DIGIT-1:0] p
);

  assign p = (2*DIGIT)'(x) * (2*DIGIT)'(y);

endmodule

// File: rtl/mul_serial.sv
// rtl/mul_serial.sv - digit-serial unsigned multiplier, full 2*WIDTH product
//
// Purpose : Computes c = a * b by accumulating (WIDTH/DIGIT)^2 shifted
//           digit products through one mul_digit instance.
// Ports   : clk  clock, rising edge
//           rst  synchronous active-high reset
//           bus  mul_serial_if.slave: in_valid/in_ready/a/b operand
//                handshake, out_valid/out_ready/c product handshake

module mul_serial
  import sm2_pkg::*;
#(
  parameter int WIDTH = SM2_WIDTH,
  parameter int DIGIT = SM2_DIGIT
) (
  input  logic         clk,
  input  logic         rst,
  mul_serial_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("mul_serial: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      i, j;

  logic               accept, step, last;
  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] prod;
  logic [2*WIDTH-1:0] partial;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = (i == LAST_IDX) && (j == LAST_IDX);
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come straight from state so no input reaches an output
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.c         = acc;

  // Digit selection by shifting keeps the index arithmetic width-clean
  assign a_dig = DIGIT'(a_q >> (DIGIT * 32'(i)));
  assign b_dig = DIGIT'(b_q >> (DIGIT * 32'(j)));

  mul_digit #(.DIGIT(DIGIT)) u_mul_digit (
    .x (a_dig),
    .y (b_dig),
    .p (prod)
  );

  // Place the digit product at weight DIGIT*(i+j); full-width add carries
  // through every upper digit of the accumulator.
  assign partial = (2*WIDTH)'(prod) << (DIGIT * (32'(i) + 32'(j)));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (step) begin
      acc <= acc + partial;
      if (j == LAST_IDX) begin
        j <= '0;
        i <= (i == LAST_IDX) ? '0 : i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_serial.sv
// tb/tb_mul_serial.sv - self-checking bench for mul_serial (three parametrisations)

module tb_mul_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one instance by sel
  logic         iv, ordy;
  logic [255:0] av, bv;
  int           sel;

  mul_serial_if #(.WIDTH(256)) if0 ();
  mul_serial_if #(.WIDTH(64))  if1 ();
  mul_serial_if #(.WIDTH(256)) if2 ();

  assign if0.in_valid  = iv && (sel == 0);
  assign if0.a         = av;
  assign if0.b         = bv;
  assign if0.out_ready = ordy && (sel == 0);

  assign if1.in_valid  = iv && (sel == 1);
  assign if1.a         = av[63:0];
  assign if1.b         = bv[63:0];
  assign if1.out_ready = ordy && (sel == 1);

  assign if2.in_valid  = iv && (sel == 2);
  assign if2.a         = av;
  assign if2.b         = bv;
  assign if2.out_ready = ordy && (sel == 2);

  mul_serial #(.WIDTH(256), .DIGIT(64)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mul_serial #(.WIDTH(64),  .DIGIT(64)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  mul_serial #(.WIDTH(256), .DIGIT(32)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic         ov, ir;
  logic [511:0] cc;

  always_comb begin
    ov = if0.out_valid;
    ir = if0.in_ready;
    cc = if0.c;
    case (sel)
      1: begin ov = if1.out_valid; ir = if1.in_ready; cc = {384'b0, if1.c}; end
      2: begin ov = if2.out_valid; ir = if2.in_ready; cc = if2.c; end
      default: ;
    endcase
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] xx, yy;
    xx = {256'b0, x};
    yy = {256'b0, y};
    return xx * yy;
  endfunction

  // Random 256-bit value with occasional all-ones / zero / sparse patterns
  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = v & {4{64'h0000_0000_0000_ffff}};
      default: ;
    endcase
    return v;
  endfunction

  // Call right after the accept edge; waits for out_valid (out_ready=1),
  // checks product, latency and in_ready after the handshake.
  task automatic wait_done(input string tag, input logic [511:0] exp, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      iv = 1'b0;
      if (ov) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check({tag, "/done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "/c"}, cc, exp);
      check({tag, "/latency"}, lat, exp_lat);
      @(negedge clk);
      check({tag, "/in_ready_after"}, ir, 1'b1);
      check({tag, "/out_valid_after"}, ov, 1'b0);
    end
  endtask

  task automatic op(input string tag, input logic [255:0] x, input logic [255:0] y,
                    input logic [511:0] exp, input int exp_lat);
    @(negedge clk);
    check({tag, "/in_ready_before"}, ir, 1'b1);
    iv   = 1'b1;
    av   = x;
    bv   = y;
    ordy = 1'b1;
    @(posedge clk);
    wait_done(tag, exp, exp_lat);
  endtask

  logic [255:0] a1, b1, a2, b2, x, y;
  bit           seen;

  initial begin
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    av   = '0;
    bv   = '0;
    sel  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset/in_ready", ir, 1'b1);
    check("reset/out_valid", ov, 1'b0);
    check("reset/c", cc, '0);

    // Directed products
    op("small", 256'd3, 256'd5, 512'd15, 16);
    op("max", '1, '1, ({512{1'b1}} - (512'b1 << 257)) + 512'd2, 16);
    op("cross", 256'b1 << 64, (256'b1 << 192) + 256'd1,
       (512'b1 << 256) + (512'b1 << 64), 16);

    // Backpressure plus an ignored in_valid pulse during RUN
    a1 = r256(); b1 = r256(); a2 = r256(); b2 = r256();
    @(negedge clk);
    iv = 1'b1; av = a1; bv = b1; ordy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(negedge clk);
    iv = 1'b1; av = a2; bv = b2;
    check("bp/busy_in_ready", ir, 1'b0);
    @(negedge clk);
    iv = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (ov) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp/done_seen", seen, 1'b1);
    iv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp/hold_c", cc, ref_mul(a1, b1));
      check("bp/hold_valid", ov, 1'b1);
      check("bp/hold_in_ready", ir, 1'b0);
      @(negedge clk);
    end
    ordy = 1'b1;
    @(negedge clk);
    check("bp/idle_after_hs", ir, 1'b1);
    check("bp/valid_after_hs", ov, 1'b0);
    @(posedge clk);
    wait_done("bp/second", ref_mul(a2, b2), 16);

    // Reset seven cycles into RUN
    @(negedge clk);
    iv = 1'b1; av = r256(); bv = r256(); ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run/out_valid", ov, 1'b0);
    check("rst_run/in_ready", ir, 1'b1);
    check("rst_run/c", cc, '0);
    op("rst_run/next", 256'd7, 256'd9, 512'd63, 16);

    // Random products, default instance
    for (int n = 0; n < 20; n++) begin
      x = r256(); y = r256();
      op("rand256_64", x, y, ref_mul(x, y), 16);
    end

    // WIDTH=64, DIGIT=64: single-digit case
    sel = 1;
    for (int n = 0; n < 1000; n++) begin
      x = {192'b0, r256() & 256'hffff_ffff_ffff_ffff};
      y = {192'b0, r256() & 256'hffff_ffff_ffff_ffff};
      op("w64_d64", x, y, ref_mul(x, y), 1);
    end

    // WIDTH=256, DIGIT=32
    sel = 2;
    op("w256_d32/max", '1, '1, ref_mul('1, '1), 64);
    for (int n = 0; n < 8; n++) begin
      x = r256(); y = r256();
      op("w256_d32", x, y, ref_mul(x, y), 64);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
